// File: rtl/bp_l15_encoder.sv
// L1.5 return path to BlackParrot memory responses: an in-order tracker of issued
// requests pairs each LOAD_RET/ST_ACK with its address and presents a registered response.
module bp_l15_encoder #(
   parameter int paddr_width_p       = 40,
   parameter int cce_block_width_p   = 512,
   parameter int mem_payload_width_p = 16,
   parameter int tracker_els_p       = 2,
   localparam int cce_mem_resp_width_lp      = 4 + 2 + mem_payload_width_p + paddr_width_p,
   localparam int cce_mem_data_resp_width_lp = cce_block_width_p + cce_mem_resp_width_lp
) (
   input  logic                                  clk_i,
   input  logic                                  reset_i,
   input  logic                                  req_issue_v_i,
   input  logic                                  req_issue_store_i,
   input  logic [paddr_width_p-1:0]              req_issue_addr_i,
   input  logic [mem_payload_width_p-1:0]        req_issue_payload_i,
   input  logic [1:0]                            req_issue_nc_size_i,
   output logic                                  tracker_full_o,
   input  logic                                  l15_transducer_val,
   input  logic [3:0]                            l15_transducer_returntype,
   input  logic [63:0]                           l15_transducer_data_0,
   input  logic [63:0]                           l15_transducer_data_1,
   output logic                                  transducer_l15_req_ack,
   output logic [cce_mem_resp_width_lp-1:0]      mem_resp_o,
   output logic                                  mem_resp_v_o,
   input  logic                                  mem_resp_ready_i,
   output logic [cce_mem_data_resp_width_lp-1:0] mem_data_resp_o,
   output logic                                  mem_data_resp_v_o,
   input  logic                                  mem_data_resp_ready_i,
   output logic                                  error_o,
   output logic [1:0]                            fsm_state
);

   // Response fields are packed {[data,] msg_type[3:0], nc_size[1:0], payload, addr}.
   // Handshake: a response transfers in any cycle where v and ready are both high;
   // v and all fields stay stable from the cycle v rises until that transfer.
   localparam logic [3:0] load_ret_c  = 4'b0000;
   localparam logic [3:0] st_ack_c    = 4'b0100;
   localparam logic [3:0] msg_rd_c    = 4'h2;
   localparam logic [3:0] msg_wr_c    = 4'h3;
   localparam int         ptr_w       = (tracker_els_p > 1) ? $clog2(tracker_els_p) : 1;
   localparam int         cnt_w       = $clog2(tracker_els_p + 1);
   localparam int         entry_w     = 1 + paddr_width_p + mem_payload_width_p + 2;
   localparam logic [cnt_w-1:0] els_c = cnt_w'(tracker_els_p);

   typedef enum logic [1:0] {e_ready, e_send_resp, e_send_data_resp} state_e;

   state_e                           state, state_n;
   logic [entry_w-1:0]               fifo_mem [tracker_els_p];
   logic [ptr_w-1:0]                 rd_ptr, wr_ptr;
   logic [cnt_w-1:0]                 count, count_n;
   logic                             full_r, err_r;
   logic [cce_mem_resp_width_lp-1:0]      resp_r;
   logic [cce_mem_data_resp_width_lp-1:0] data_resp_r;

   logic [entry_w-1:0]               head;
   logic                             head_store;
   logic [paddr_width_p-1:0]         head_addr;
   logic [mem_payload_width_p-1:0]   head_payload;
   logic [1:0]                       head_size;
   logic                             resp_hs, slot_free, consume, is_load, is_st;
   logic                             fifo_empty, pop, match_load, match_st;
   logic                             push_ok, push_err, ret_err;
   logic [63:0]                      sel_word, le_word, shifted, size_mask;
   logic [cce_block_width_p-1:0]     load_data;

   function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
      return (p == ptr_w'(tracker_els_p - 1)) ? '0 : p + ptr_w'(1);
   endfunction

   assign head         = fifo_mem[rd_ptr];
   assign head_store   = head[entry_w-1];
   assign head_addr    = head[entry_w-2 -: paddr_width_p];
   assign head_payload = head[2 +: mem_payload_width_p];
   assign head_size    = head[1:0];

   assign resp_hs    = (state == e_send_resp && mem_resp_ready_i)
                    || (state == e_send_data_resp && mem_data_resp_ready_i);
   assign slot_free  = (state == e_ready) || resp_hs;
   assign consume    = l15_transducer_val && slot_free;
   assign is_load    = (l15_transducer_returntype == load_ret_c);
   assign is_st      = (l15_transducer_returntype == st_ack_c);
   assign fifo_empty = (count == '0);
   assign pop        = consume && (is_load || is_st) && !fifo_empty;
   assign match_load = pop && is_load && !head_store;
   assign match_st   = pop && is_st && head_store;
   // A pop in the same cycle frees the slot a push into a full tracker needs.
   assign push_ok    = req_issue_v_i && (!full_r || pop);
   assign push_err   = req_issue_v_i && full_r && !pop;
   assign ret_err    = consume && (is_load || is_st) && (fifo_empty || (pop && !match_load && !match_st));

   always_comb begin
      sel_word = head_addr[3] ? l15_transducer_data_1 : l15_transducer_data_0;
      le_word  = '0;
      for (int i = 0; i < 8; i++) le_word[8*i +: 8] = sel_word[8*(7-i) +: 8];
      shifted  = (head_size == 2'd3) ? le_word : (le_word >> {head_addr[2:0], 3'b000});
      case (head_size)
         2'd0:    size_mask = 64'h0000_0000_0000_00ff;
         2'd1:    size_mask = 64'h0000_0000_0000_ffff;
         2'd2:    size_mask = 64'h0000_0000_ffff_ffff;
         default: size_mask = '1;
      endcase
      load_data       = '0;
      load_data[63:0] = shifted & size_mask;
   end

   always_comb begin
      state_n = state;
      if (resp_hs)         state_n = e_ready;
      if (match_load)      state_n = e_send_data_resp;
      else if (match_st)   state_n = e_send_resp;
   end

   always_comb begin
      count_n = count;
      if (push_ok && !pop)      count_n = count + cnt_w'(1);
      else if (!push_ok && pop) count_n = count - cnt_w'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) state <= e_ready;
      else         state <= state_n;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         full_r      <= 1'b0;
         err_r       <= 1'b0;
         resp_r      <= '0;
         data_resp_r <= '0;
      end else begin
         if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)     rd_ptr <= ptr_inc(rd_ptr);
         count  <= count_n;
         full_r <= (count_n == els_c);
         if (push_err || ret_err) err_r <= 1'b1;
         if (match_load) data_resp_r <= {load_data, msg_rd_c, head_size, head_payload, head_addr};
         if (match_st)   resp_r      <= {msg_wr_c, head_size, head_payload, head_addr};
      end
   end

   // Storage needs no reset: the count gates every read.
   always_ff @(posedge clk_i) begin
      if (push_ok)
         fifo_mem[wr_ptr] <= {req_issue_store_i, req_issue_addr_i, req_issue_payload_i, req_issue_nc_size_i};
   end

   assign tracker_full_o         = full_r;
   assign error_o                = err_r;
   assign transducer_l15_req_ack = consume;
   assign mem_resp_o             = resp_r;
   assign mem_resp_v_o           = (state == e_send_resp);
   assign mem_data_resp_o        = data_resp_r;
   assign mem_data_resp_v_o      = (state == e_send_data_resp);
   assign fsm_state              = state;

endmodule

// File: tb/tb_bp_l15_encoder.sv
// Bench for bp_l15_encoder: directed scenarios plus random traffic, checked against a
// queue-based model of outstanding requests and expected responses.
module tb_bp_l15_encoder;

   localparam int PA = 40, BLK = 128, PL = 16, ELS = 2;
   localparam int RW = 4 + 2 + PL + PA;
   localparam int DRW = BLK + RW;
   localparam int EW = 1 + DRW;
   localparam logic [3:0] LOAD = 4'h0, ST = 4'h4, EVICT = 4'h3, INTR = 4'h7;

   typedef struct {
      bit st;
      logic [PA-1:0] a;
      logic [PL-1:0] p;
      logic [1:0] sz;
   } req_t;

   logic clk = 0, reset = 1;
   logic iv = 0, ist = 0, lv = 0, rdy_resp = 0, rdy_data = 0;
   logic [PA-1:0] ia = '0;
   logic [PL-1:0] ip = '0;
   logic [1:0] isz = '0;
   logic [3:0] lt = '0;
   logic [63:0] d0 = '0, d1 = '0;
   logic full, ack, resp_v, data_resp_v, err;
   logic [RW-1:0] resp;
   logic [DRW-1:0] data_resp;
   logic [1:0] st_dbg;

   bp_l15_encoder #(.paddr_width_p(PA), .cce_block_width_p(BLK), .mem_payload_width_p(PL),
                    .tracker_els_p(ELS)) dut (
      .clk_i(clk), .reset_i(reset),
      .req_issue_v_i(iv), .req_issue_store_i(ist), .req_issue_addr_i(ia),
      .req_issue_payload_i(ip), .req_issue_nc_size_i(isz), .tracker_full_o(full),
      .l15_transducer_val(lv), .l15_transducer_returntype(lt),
      .l15_transducer_data_0(d0), .l15_transducer_data_1(d1),
      .transducer_l15_req_ack(ack),
      .mem_resp_o(resp), .mem_resp_v_o(resp_v), .mem_resp_ready_i(rdy_resp),
      .mem_data_resp_o(data_resp), .mem_data_resp_v_o(data_resp_v),
      .mem_data_resp_ready_i(rdy_data),
      .error_o(err), .fsm_state(st_dbg));

   always #5 clk = ~clk;

   // model state
   req_t pend_q[$];
   logic [EW-1:0] exp_q[$];
   bit busy = 0, err_m = 0;
   int n_checks = 0, n_pass = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Addressed bytes taken from the big-endian word in memory order, placed from bit 0 up.
   function automatic logic [63:0] model_load(logic [PA-1:0] a, logic [1:0] sz, logic [63:0] w0, logic [63:0] w1);
      logic [63:0] w = a[3] ? w1 : w0;
      logic [63:0] r = '0;
      int n = 1 << sz;
      int base = (sz == 2'd3) ? 0 : int'(a[2:0]);
      for (int i = 0; i < n; i++)
         if (base + i < 8) r[8*i +: 8] = w[63 - 8*(base + i) -: 8];
      return r;
   endfunction

   task automatic check_outputs();
      logic [EW-1:0] front;
      front = busy ? exp_q[0] : '0;
      check("full", full, pend_q.size() == ELS);
      check("error", err, err_m);
      check("data_v", data_resp_v, busy && front[EW-1]);
      check("resp_v", resp_v, busy && !front[EW-1]);
      if (busy && front[EW-1]) check("data_resp", data_resp, front[DRW-1:0]);
      if (busy && !front[EW-1]) check("resp", resp, front[RW-1:0]);
   endtask

   task automatic step(input bit s_iv, input bit s_st, input logic [PA-1:0] s_a, input logic [PL-1:0] s_p,
                       input logic [1:0] s_sz, input bit s_lv, input logic [3:0] s_t,
                       input logic [63:0] s_d0, input logic [63:0] s_d1, input bit s_rdy, output bit acked);
      bit hs, exp_ack, popped;
      req_t h, r;
      @(negedge clk);
      iv = s_iv; ist = s_st; ia = s_a; ip = s_p; isz = s_sz;
      lv = s_lv; lt = s_t; d0 = s_d0; d1 = s_d1; rdy_resp = s_rdy; rdy_data = s_rdy;
      #1;
      hs = busy && s_rdy;
      exp_ack = s_lv && (!busy || hs);
      check("ack", ack, exp_ack);
      acked = ack;
      if (hs) begin
         void'(exp_q.pop_front());
         busy = 0;
      end
      popped = 0;
      if (exp_ack && (s_t == LOAD || s_t == ST)) begin
         if (pend_q.size() == 0) err_m = 1;
         else begin
            h = pend_q.pop_front();
            popped = 1;
            if (s_t == LOAD && !h.st) begin
               exp_q.push_back({1'b1, 64'd0, model_load(h.a, h.sz, s_d0, s_d1), 4'h2, h.sz, h.p, h.a});
               busy = 1;
            end else if (s_t == ST && h.st) begin
               exp_q.push_back({1'b0, {BLK{1'b0}}, 4'h3, h.sz, h.p, h.a});
               busy = 1;
            end else err_m = 1;
         end
      end
      if (s_iv) begin
         if (pend_q.size() == ELS && !popped) err_m = 1;
         else begin
            r.st = s_st; r.a = s_a; r.p = s_p; r.sz = s_sz;
            pend_q.push_back(r);
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic issue(input bit s_st, input logic [PA-1:0] s_a, input logic [PL-1:0] s_p, input logic [1:0] s_sz);
      bit a;
      step(1, s_st, s_a, s_p, s_sz, 0, 4'h0, 64'd0, 64'd0, 1, a);
   endtask

   task automatic ret(input logic [3:0] t, input logic [63:0] w0, input logic [63:0] w1, input bit rdy);
      bit a;
      step(0, 0, '0, '0, 2'd0, 1, t, w0, w1, rdy, a);
   endtask

   task automatic idle(input bit rdy);
      bit a;
      step(0, 0, '0, '0, 2'd0, 0, 4'h0, 64'd0, 64'd0, rdy, a);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1; iv = 0; lv = 0; rdy_resp = 0; rdy_data = 0;
      @(posedge clk);
      @(negedge clk);
      reset = 0;
      pend_q.delete(); exp_q.delete(); busy = 0; err_m = 0;
      #1;
      check_outputs();
      check("ack_reset", ack, 1'b0);
   endtask

   initial begin
      bit a, cur_lv;
      logic [3:0] cur_t;
      logic [63:0] cur_d0, cur_d1;
      logic [PA-1:0] ra;
      logic [1:0] rsz;
      int r, guard;

      repeat (2) @(posedge clk);
      do_reset();

      // 8B load from the upper word
      issue(0, 40'h80_0000_0008, 16'hbeef, 2'd3);
      ret(LOAD, 64'hdead_beef_dead_beef, 64'h0102030405060708, 0);
      check("tp1_data", data_resp[125:62], 64'h0807060504030201);
      idle(0);
      idle(1);
      // 1B load at offset 3
      issue(0, 40'h80_0000_0003, 16'h0042, 2'd0);
      ret(LOAD, 64'h0011223344556677, 64'hffff_ffff_ffff_ffff, 1);
      check("tp2_data", data_resp[189:62], 128'h33);
      idle(1);

      // store under backpressure, a load return waits behind it
      issue(1, 40'h80_0000_0100, 16'h0101, 2'd3);
      issue(0, 40'h80_0000_0200, 16'h0202, 2'd2);
      ret(ST, 64'd0, 64'd0, 0);
      ret(LOAD, 64'h1122334455667788, 64'd0, 0);
      ret(LOAD, 64'h1122334455667788, 64'd0, 0);
      ret(LOAD, 64'h1122334455667788, 64'd0, 0);
      ret(LOAD, 64'h1122334455667788, 64'd0, 1);
      idle(1);

      // full tracker, push in the pop cycle, in-order load, load, store
      issue(0, 40'h80_0000_0010, 16'h0010, 2'd1);
      issue(0, 40'h80_0000_0028, 16'h0028, 2'd3);
      step(1, 1, 40'h80_0000_0030, 16'h0030, 2'd3, 1, LOAD, 64'h0a0b0c0d0e0f1011, 64'd0, 1, a);
      ret(LOAD, 64'd0, 64'h8899aabbccddeeff, 1);
      ret(ST, 64'd0, 64'd0, 1);
      idle(1);

      // evict between a load and its return
      issue(0, 40'h80_0000_0044, 16'h0044, 2'd2);
      ret(EVICT, 64'd5, 64'd6, 1);
      ret(INTR, 64'd7, 64'd8, 1);
      ret(LOAD, 64'h0123456789abcdef, 64'd0, 1);
      idle(1);

      // protocol errors: ST_ACK with empty tracker, type mismatch, push while full
      ret(ST, 64'd0, 64'd0, 1);
      idle(1);
      issue(0, 40'h80_0000_0050, 16'h0050, 2'd3);
      ret(ST, 64'd0, 64'd0, 1);
      idle(1);
      do_reset();
      issue(0, 40'h80_0000_0060, 16'h0060, 2'd3);
      issue(0, 40'h80_0000_0068, 16'h0068, 2'd3);
      issue(1, 40'h80_0000_0070, 16'h0070, 2'd3);
      do_reset();

      // reset while a load response is pending, with another entry queued
      issue(0, 40'h80_0000_0080, 16'h0080, 2'd3);
      issue(0, 40'h80_0000_0088, 16'h0088, 2'd3);
      ret(LOAD, 64'h1, 64'h2, 0);
      idle(0);
      do_reset();
      ret(LOAD, 64'h1, 64'h2, 1);
      idle(1);
      do_reset();

      // random traffic
      cur_lv = 0; cur_t = LOAD; cur_d0 = '0; cur_d1 = '0;
      for (int c = 0; c < 400; c++) begin
         if (!cur_lv) begin
            r = $urandom_range(0, 9);
            cur_d0 = {$urandom(), $urandom()};
            cur_d1 = {$urandom(), $urandom()};
            if (pend_q.size() > 0 && r < 6) begin
               cur_lv = 1;
               cur_t = pend_q[0].st ? ST : LOAD;
            end else if (r < 8) begin
               cur_lv = 1;
               cur_t = (r == 6) ? EVICT : INTR;
            end
         end
         rsz = 2'($urandom_range(0, 3));
         ra = {8'h80, 32'($urandom())};
         ra = ra & ~((40'd1 << rsz) - 40'd1);
         step((pend_q.size() < ELS) && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1,
              ra, 16'($urandom()), rsz, cur_lv, cur_t, cur_d0, cur_d1, $urandom_range(0, 3) != 0, a);
         if (a) cur_lv = 0;
      end
      guard = 0;
      while (cur_lv && guard < 20) begin
         step(0, 0, '0, '0, 2'd0, 1, cur_t, cur_d0, cur_d1, 1, a);
         if (a) cur_lv = 0;
         guard++;
      end
      check("drain_ack", cur_lv, 1'b0);
      idle(1);
      idle(1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
